snoop_resp_fsm_lv1: RTL and testbench

//  Per-L1 snoop responder; consumes the snoop hit flag and the hit way's MESI state from the snoop tag lookup.
//  For each snooped bus transaction (bus_rd/bus_rdx/invalidate) it drives the shared response,

---
 rtl/snoop_resp_if.sv | 37 +++
 rtl/snoop_resp_fsm_lv1.sv | 112 +++++++++++
 tb/tb_snoop_resp_fsm_lv1.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/snoop_resp_if.sv
// Snoop request/response bundle between the snoop tag lookup, the bus and the L1 snoop responder.
`ifndef ASSOC_LV1
`define ASSOC_LV1 4
`endif

interface snoop_resp_if #(
    parameter int unsigned ASSOC = `ASSOC_LV1
) ();
    logic             bus_rd;
    logic             bus_rdx;
    logic             invalidate;
    logic             blk_hit_snoop;
    logic [ASSOC-1:0] access_blk_snoop;
    logic [1:0]       blk_state_snoop;
    logic             flush_ack;
    logic             shared_snoop;
    logic             flush_req;
    logic             mesi_wr_en;
    logic [ASSOC-1:0] mesi_wr_way;
    logic [1:0]       mesi_wr_state;
    logic             snoop_done;
    logic             snoop_err;

    modport master (
        output bus_rd, bus_rdx, invalidate, blk_hit_snoop, access_blk_snoop,
               blk_state_snoop, flush_ack,
        input  shared_snoop, flush_req, mesi_wr_en, mesi_wr_way, mesi_wr_state,
               snoop_done, snoop_err
    );

    modport slave (
        input  bus_rd, bus_rdx, invalidate, blk_hit_snoop, access_blk_snoop,
               blk_state_snoop, flush_ack,
        output shared_snoop, flush_req, mesi_wr_en, mesi_wr_way, mesi_wr_state,
               snoop_done, snoop_err
    );
endinterface

// File: rtl/snoop_resp_fsm_lv1.sv
// Per-L1 snoop responder: answers a snooped bus transaction, flushes Modified lines,
// writes the next MESI state back and pulses completion.
`ifndef ASSOC_LV1
`define ASSOC_LV1 4
`endif

module snoop_resp_fsm_lv1 #(
    parameter int unsigned ASSOC         = `ASSOC_LV1,
    parameter int unsigned FLUSH_TIMEOUT = 64
) (
    input logic         clk,
    input logic         rst_n,
    snoop_resp_if.slave sif
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RESP   = 3'd1;
    localparam logic [2:0] FLUSH  = 3'd2;
    localparam logic [2:0] UPDATE = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_RDX  = 2'd2;
    localparam logic [1:0] OP_INV  = 2'd3;

    localparam logic [1:0] MESI_I = 2'b00;
    localparam logic [1:0] MESI_S = 2'b01;
    localparam logic [1:0] MESI_M = 2'b11;

    localparam int unsigned    CW       = $clog2(FLUSH_TIMEOUT) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(FLUSH_TIMEOUT - 1);

    logic [2:0]       state;
    logic [1:0]       op_q;
    logic [ASSOC-1:0] way_q;
    logic [1:0]       blk_q;
    logic [1:0]       wr_state_q;
    logic [CW-1:0]    cnt;

    logic       req;
    logic       req_multi;
    logic       valid_hit;
    logic [1:0] sel_op;
    logic       flush_timeout;

    always_comb begin
        req       = sif.bus_rd | sif.bus_rdx | sif.invalidate;
        req_multi = (sif.bus_rd & sif.bus_rdx) | (sif.bus_rd & sif.invalidate) |
                    (sif.bus_rdx & sif.invalidate);
        valid_hit = sif.blk_hit_snoop && (sif.blk_state_snoop != MESI_I);
        if (sif.bus_rdx)         sel_op = OP_RDX;
        else if (sif.bus_rd)     sel_op = OP_RD;
        else if (sif.invalidate) sel_op = OP_INV;
        else                     sel_op = OP_NONE;
        flush_timeout = (cnt == CNT_LAST) && !sif.flush_ack;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= OP_NONE;
            way_q      <= '0;
            blk_q      <= MESI_I;
            wr_state_q <= MESI_I;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && valid_hit) begin
                        op_q       <= sel_op;
                        way_q      <= sif.access_blk_snoop;
                        blk_q      <= sif.blk_state_snoop;
                        // Only a read leaves a sharer behind; rdx and invalidate both drop to I.
                        wr_state_q <= (sel_op == OP_RD) ? MESI_S : MESI_I;
                        state      <= RESP;
                    end else if (req) begin
                        state <= DONE;
                    end
                end
                RESP: begin
                    cnt <= '0;
                    if (blk_q == MESI_M && op_q != OP_INV) state <= FLUSH;
                    else                                   state <= UPDATE;
                end
                FLUSH: begin
                    if (sif.flush_ack || flush_timeout) begin
                        cnt   <= '0;
                        state <= UPDATE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                UPDATE:  state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        sif.shared_snoop  = ((state == RESP) || (state == FLUSH)) && (op_q == OP_RD);
        sif.flush_req     = (state == FLUSH);
        sif.mesi_wr_en    = (state == UPDATE);
        sif.mesi_wr_way   = way_q;
        sif.mesi_wr_state = wr_state_q;
        sif.snoop_done    = (state == DONE);
        // IDLE-cycle error is combinational on the request lines, so gate it while reset is held.
        sif.snoop_err     = ((state == IDLE) && req_multi && rst_n) ||
                            ((state == RESP) && (op_q == OP_INV) && (blk_q == MESI_M)) ||
                            ((state == FLUSH) && flush_timeout);
    end
endmodule

// File: tb/tb_snoop_resp_fsm_lv1.sv
// Bench for snoop_resp_fsm_lv1: a transaction-level model predicts the output trace of every
// cycle, a negedge process compares it, and directed cases pin latencies with literal values.
module tb_snoop_resp_fsm_lv1;
    localparam int unsigned A = 4;
    localparam int unsigned T = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    snoop_resp_if #(.ASSOC(A)) sif ();

    snoop_resp_fsm_lv1 #(.ASSOC(A), .FLUSH_TIMEOUT(T)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sif  (sif)
    );

    typedef struct packed {
        logic         shared;
        logic         flush;
        logic         wr;
        logic [A-1:0] way;
        logic [1:0]   wst;
        logic         done;
        logic         err;
    } exp_t;

    exp_t         exp_q[$];
    int           tests = 0;
    int           fails = 0;
    logic [A-1:0] m_way = '0;
    logic [1:0]   m_wst = 2'b00;

    int           ncyc = 0;
    int           t0;
    int           done_cyc;
    int           wr_cnt, flush_cnt, err_cnt, shared_cnt;
    logic [A-1:0] last_way;
    logic [1:0]   last_wst;

    int cyc;
    int abort_at;
    bit aborted;

    function automatic exp_t mk(input logic sh, input logic fl, input logic wr,
                                input logic dn, input logic er);
        exp_t e;
        e.shared = sh; e.flush = fl; e.wr = wr;
        e.way = m_way; e.wst = m_wst;
        e.done = dn; e.err = er;
        return e;
    endfunction

    function automatic logic [A-1:0] onehot();
        logic [A-1:0] w;
        w = '0;
        w[$urandom_range(A-1, 0)] = 1'b1;
        return w;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        ncyc++;
        if (sif.snoop_done)   done_cyc = ncyc;
        if (sif.flush_req)    flush_cnt++;
        if (sif.snoop_err)    err_cnt++;
        if (sif.shared_snoop) shared_cnt++;
        if (sif.mesi_wr_en) begin
            wr_cnt++;
            last_way = sif.mesi_wr_way;
            last_wst = sif.mesi_wr_state;
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {sif.shared_snoop, sif.flush_req, sif.mesi_wr_en, sif.mesi_wr_way,
                 sif.mesi_wr_state, sif.snoop_done, sif.snoop_err};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle_%0d outputs {shared,flush,wr_en,way,wst,done,err}: got %b %b %b %b %b %b %b, expected %b %b %b %b %b %b %b",
                         ncyc, a.shared, a.flush, a.wr, a.way, a.wst, a.done, a.err,
                         e.shared, e.flush, e.wr, e.way, e.wst, e.done, e.err);
            end
        end
    end

    task automatic pin(input string name, input int act, input int ex);
        tests++;
        if (act != ex) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, ex);
        end
    endtask

    task automatic clear_mon();
        done_cyc = -1; wr_cnt = 0; flush_cnt = 0; err_cnt = 0; shared_cnt = 0;
        last_way = '0; last_wst = 2'b00;
    endtask

    task automatic drive(input logic rd, input logic rdx, input logic inv, input logic hit,
                         input logic [A-1:0] way, input logic [1:0] st, input logic ack);
        sif.bus_rd = rd; sif.bus_rdx = rdx; sif.invalidate = inv;
        sif.blk_hit_snoop = hit; sif.access_blk_snoop = way; sif.blk_state_snoop = st;
        sif.flush_ack = ack;
    endtask

    task automatic do_reset();
        exp_t z;
        z = '0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 1'b0);
        #1;
        tests++;
        if ({sif.shared_snoop, sif.flush_req, sif.mesi_wr_en, sif.mesi_wr_way,
             sif.mesi_wr_state, sif.snoop_done, sif.snoop_err} !== '0) begin
            fails++;
            $display("FAIL async_reset_outputs: got nonzero outputs, expected all zero");
        end
        m_way = '0;
        m_wst = 2'b00;
        exp_q.push_back(z);
        @(posedge clk); #1;
        exp_q.push_back(z);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic step(input logic rd, input logic rdx, input logic inv, input logic hit,
                        input logic [A-1:0] way, input logic [1:0] st, input logic ack,
                        input exp_t e);
        if (aborted) return;
        if (cyc == abort_at) begin
            do_reset();
            aborted = 1'b1;
            return;
        end
        drive(rd, rdx, inv, hit, way, st, ack);
        exp_q.push_back(e);
        @(posedge clk); #1;
        cyc++;
    endtask

    // Non-IDLE cycle: request held, tag lookup lines carry noise that must be ignored.
    task automatic nstep(input logic rd, input logic rdx, input logic inv, input logic ack,
                         input exp_t e);
        step(rd, rdx, inv, 1'($urandom_range(1, 0)), onehot(), 2'($urandom_range(3, 0)), ack, e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'($urandom_range(1, 0)), onehot(),
                  2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            @(posedge clk); #1;
        end
    endtask

    task automatic run_txn(input logic rd, input logic rdx, input logic inv, input logic hit,
                           input logic [A-1:0] way, input logic [1:0] st,
                           input int ack_k, input int abort_idx);
        int   op;
        logic multi;
        logic vhit;
        logic m_flush;
        int   nfl;
        cyc = 0; aborted = 1'b0; abort_at = abort_idx;
        t0 = ncyc + 1;
        op    = rdx ? 2 : (rd ? 1 : 3);
        multi = (int'(rd) + int'(rdx) + int'(inv)) > 1;
        vhit  = hit && (st != 2'b00);
        step(rd, rdx, inv, hit, way, st, 1'($urandom_range(1, 0)),
             mk(1'b0, 1'b0, 1'b0, 1'b0, multi));
        if (!vhit) begin
            nstep(rd, rdx, inv, 1'($urandom_range(1, 0)), mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
            return;
        end
        m_way = way;
        m_wst = (op == 1) ? 2'b01 : 2'b00;
        m_flush = (st == 2'b11) && (op != 3);
        nstep(rd, rdx, inv, 1'($urandom_range(1, 0)),
              mk(op == 1, 1'b0, 1'b0, 1'b0, (op == 3) && (st == 2'b11)));
        if (m_flush) begin
            nfl = (ack_k == 0) ? T : ack_k;
            for (int j = 1; j <= nfl; j++)
                nstep(rd, rdx, inv, j == ack_k,
                      mk(op == 1, 1'b1, 1'b0, 1'b0, (ack_k == 0) && (j == T)));
        end
        nstep(rd, rdx, inv, 1'($urandom_range(1, 0)), mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        nstep(rd, rdx, inv, 1'($urandom_range(1, 0)), mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        pin("reset_outputs", int'({sif.shared_snoop, sif.flush_req, sif.mesi_wr_en, sif.mesi_wr_way,
                                   sif.mesi_wr_state, sif.snoop_done, sif.snoop_err}), 0);
        rst_n = 1'b1;
        idle(2);

        clear_mon();
        run_txn(1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 2'b10, 0, -1);
        pin("rd_E_done_latency", done_cyc - t0, 3);
        pin("rd_E_wr_way", int'(last_way), 2);
        pin("rd_E_wr_state", int'(last_wst), 1);
        pin("rd_E_shared_cycles", shared_cnt, 1);
        idle(1);

        clear_mon();
        run_txn(1'b0, 1'b1, 1'b0, 1'b1, 4'b1000, 2'b11, 5, -1);
        pin("rdx_M_flush_cycles", flush_cnt, 5);
        pin("rdx_M_wr_state", int'(last_wst), 0);
        pin("rdx_M_errors", err_cnt, 0);
        pin("rdx_M_done_latency", done_cyc - t0, 8);
        idle(1);

        clear_mon();
        run_txn(1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 2'b11, 0, -1);
        pin("rd_M_timeout_errors", err_cnt, 1);
        pin("rd_M_timeout_flush_cycles", flush_cnt, T);
        pin("rd_M_timeout_wr_state", int'(last_wst), 1);
        pin("rd_M_timeout_done_latency", done_cyc - t0, 3 + T);
        idle(1);

        clear_mon();
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 2'b10, 0, -1);
        pin("miss_done_latency", done_cyc - t0, 1);
        pin("miss_writes", wr_cnt, 0);
        pin("miss_shared", shared_cnt, 0);
        idle(1);

        clear_mon();
        run_txn(1'b1, 1'b0, 1'b1, 1'b1, 4'b0001, 2'b01, 0, -1);
        pin("rd_inv_errors", err_cnt, 1);
        pin("rd_inv_wr_state", int'(last_wst), 1);
        pin("rd_inv_shared_cycles", shared_cnt, 1);
        idle(1);

        clear_mon();
        run_txn(1'b0, 1'b0, 1'b1, 1'b1, 4'b0100, 2'b11, 0, -1);
        pin("inv_M_errors", err_cnt, 1);
        pin("inv_M_flush_cycles", flush_cnt, 0);
        pin("inv_M_wr_state", int'(last_wst), 0);
        idle(1);

        clear_mon();
        run_txn(1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, 2'b11, 0, 4);
        pin("reset_in_flush_writes", wr_cnt, 0);
        pin("reset_in_flush_done", done_cyc, -1);
        idle(2);

        for (int i = 0; i < 300; i++) begin
            logic [2:0] pat;
            int         ack_k;
            int         ab;
            pat   = 3'($urandom_range(7, 1));
            ack_k = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(T, 1));
            ab    = ($urandom_range(19, 0) == 0) ? int'($urandom_range(6, 1)) : -1;
            run_txn(pat[0], pat[1], pat[2], $urandom_range(3, 0) != 0, onehot(),
                    2'($urandom_range(3, 0)), ack_k, ab);
            idle(int'($urandom_range(2, 0)));
        end

        idle(2);
        pin("expectation_queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
